// File: rtl/util_fir_dec_pkg.sv
// util_fir_dec_pkg
//   Shared constants, types and helpers for the util_fir_dec RX decimator.
//   SAMPLE_W          : ADC sample width (two's complement).
//   BEAT_W            : AXI-Stream beat width, {ch1, ch0}.
//   DEC_LOG2_DEFAULT  : default log2 of the decimation ratio.
//   ACC_W             : accumulator width for the default ratio; acc_width()
//                       gives it for any ratio.
//   mode_e            : registered copy of the decimate control.
//   sample_pair_t     : signed {ch1, ch0} sample pair.
package util_fir_dec_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int BEAT_W           = 2 * SAMPLE_W;
    localparam int DEC_LOG2_DEFAULT = 3;
    localparam int ACC_W            = SAMPLE_W + DEC_LOG2_DEFAULT;

    typedef enum logic {
        MODE_PASS = 1'b0,
        MODE_DEC  = 1'b1
    } mode_e;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] ch1;
        logic signed [SAMPLE_W-1:0] ch0;
    } sample_pair_t;

    function automatic int acc_width(input int dec_log2);
        return SAMPLE_W + dec_log2;
    endfunction

    function automatic logic [BEAT_W-1:0] pack_beat(input logic [SAMPLE_W-1:0] ch1,
                                                    input logic [SAMPLE_W-1:0] ch0);
        return {ch1, ch0};
    endfunction

endpackage

// File: rtl/util_fir_dec_fifo.sv
// util_fir_dec_fifo
//   Synchronous FIFO with a registered head (first-word-fall-through).
//   The head register is a copy of the oldest entry, so the occupancy count
//   includes it and the FIFO holds exactly DEPTH beats.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     wr_en_i     : write request (accepted when not full, or when popping)
//     wr_data_i   : write data
//     rd_en_i     : consumer ready; pops the head when head_vld_o is set
//     rd_data_o   : registered head data
//     head_vld_o  : registered head valid (FIFO non-empty at the head)
//     full_o      : all DEPTH slots occupied
module util_fir_dec_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             head_vld_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO = (AW+1)'(2);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic             wr_ok, rd_ok;

    assign full_o     = (count_q == CNT_MAX);
    assign rd_ok      = rd_en_i && head_vld_q;
    assign wr_ok      = wr_en_i && (!full_o || rd_ok);
    assign rd_data_o  = head_q;
    assign head_vld_o = head_vld_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Head reloads from memory only on a pop or when empty; a beat written
        // this cycle lands in the head one cycle later, so it stays stable
        // while stalled and the read never races the write.
        if (rd_ok) begin
            head_vld_d = (count_q >= CNT_TWO);
            if (count_q >= CNT_TWO) head_d = mem_q[rd_ptr_d];
        end else if (!head_vld_q && count_q != '0) begin
            head_vld_d = 1'b1;
            head_d     = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/util_fir_dec.sv
// util_fir_dec
//   RX decimator: paired 16-bit ADC samples, optional boxcar accumulate-and-
//   dump by R = 2**DEC_LOG2, output as 32-bit AXI-Stream {ch1, ch0} through a
//   small FIFO. Define UTIL_FIR_DEC_ROUND_EN to round half up (with clip to
//   0x7FFF) instead of flooring on the dump.
//   Ports:
//     aclk, reset          : clock, synchronous active-high reset
//     adc_valid            : sample-pair strobe (cannot be stalled)
//     adc_data_0/1         : channel 0/1 samples
//     decimate             : 1 = average R samples, 0 = pass-through
//     m_axis_data_*        : AXI-Stream master (tvalid/tready/tdata)
//     ovf                  : sticky, a beat was dropped on a full FIFO
//     ovf_clr              : clears ovf (a new drop wins)
module util_fir_dec
    import util_fir_dec_pkg::*;
#(
    parameter int DEC_LOG2   = DEC_LOG2_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              adc_valid,
    input  logic [15:0]       adc_data_0,
    input  logic [15:0]       adc_data_1,
    input  logic              decimate,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic [BEAT_W-1:0] m_axis_data_tdata,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int AW = acc_width(DEC_LOG2);
    localparam logic [DEC_LOG2-1:0] PH_ONE = DEC_LOG2'(1);
`ifdef UTIL_FIR_DEC_ROUND_EN
    localparam logic signed [AW:0] RND_C = (AW+1)'((1 << DEC_LOG2) / 2);
    localparam logic signed [AW:0] MAX_C = (AW+1)'(32767);
`endif

    sample_pair_t             in_pair;
    mode_e                    mode_in, mode_q;
    logic                     mode_chg;
    logic signed [AW-1:0]     s0, s1;
    logic signed [AW-1:0]     acc0_q, acc0_d, acc1_q, acc1_d;
    logic [DEC_LOG2-1:0]      phase_q, phase_d, eff_phase;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     beat_vld_q, beat_vld_d;
    logic                     ovf_q, ovf_d;
    logic                     fifo_full, pop, drop;

    function automatic logic [15:0] dump(input logic signed [AW-1:0] sum);
`ifdef UTIL_FIR_DEC_ROUND_EN
        logic signed [AW:0] q;
        q = ((AW+1)'(sum) + RND_C) >>> DEC_LOG2;
        if (q > MAX_C) return 16'h7FFF;
        return 16'(q);
`else
        return 16'(sum >>> DEC_LOG2);
`endif
    endfunction

    assign in_pair   = {adc_data_1, adc_data_0};
    assign s0        = AW'(in_pair.ch0);
    assign s1        = AW'(in_pair.ch1);
    assign mode_in   = decimate ? MODE_DEC : MODE_PASS;
    assign mode_chg  = (mode_in != mode_q);
    // A sample arriving with a mode change starts the new mode at phase 0.
    assign eff_phase = mode_chg ? '0 : phase_q;

    always_comb begin
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        phase_d    = phase_q;
        beat_d     = beat_q;
        beat_vld_d = 1'b0;
        if (mode_chg) begin
            acc0_d  = '0;
            acc1_d  = '0;
            phase_d = '0;
        end
        if (adc_valid) begin
            if (mode_in == MODE_PASS) begin
                beat_d     = pack_beat(in_pair.ch1, in_pair.ch0);
                beat_vld_d = 1'b1;
            end else begin
                if (eff_phase == '0) begin
                    acc0_d = s0;
                    acc1_d = s1;
                end else begin
                    acc0_d = acc0_q + s0;
                    acc1_d = acc1_q + s1;
                end
                if (&eff_phase) begin
                    beat_d     = pack_beat(dump(acc1_d), dump(acc0_d));
                    beat_vld_d = 1'b1;
                    phase_d    = '0;
                end else begin
                    phase_d = eff_phase + PH_ONE;
                end
            end
        end
    end

    assign pop   = m_axis_data_tvalid && m_axis_data_tready;
    assign drop  = beat_vld_q && fifo_full && !pop;
    assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge aclk) begin
        if (reset) begin
            mode_q     <= MODE_PASS;
            acc0_q     <= '0;
            acc1_q     <= '0;
            phase_q    <= '0;
            beat_q     <= '0;
            beat_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            mode_q     <= mode_in;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            phase_q    <= phase_d;
            beat_q     <= beat_d;
            beat_vld_q <= beat_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    util_fir_dec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk        (aclk),
        .rst        (reset),
        .wr_en_i    (beat_vld_q),
        .wr_data_i  (beat_q),
        .rd_en_i    (m_axis_data_tready),
        .rd_data_o  (m_axis_data_tdata),
        .head_vld_o (m_axis_data_tvalid),
        .full_o     (fifo_full)
    );

endmodule

// File: tb/tb_util_fir_dec.sv
// tb_util_fir_dec
//   Directed bench for util_fir_dec (DEC_LOG2=3, FIFO_DEPTH=4). Honours
//   UTIL_FIR_DEC_ROUND_EN for the rounding-dependent expectation.
module tb_util_fir_dec;

    logic        aclk = 1'b0;
    logic        reset, adc_valid, decimate, tready, ovf_clr;
    logic [15:0] d0, d1;
    logic        tvalid, ovf;
    logic [31:0] tdata;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 aclk = ~aclk;

    util_fir_dec #(
        .DEC_LOG2   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .aclk               (aclk),
        .reset              (reset),
        .adc_valid          (adc_valid),
        .adc_data_0         (d0),
        .adc_data_1         (d1),
        .decimate           (decimate),
        .m_axis_data_tvalid (tvalid),
        .m_axis_data_tready (tready),
        .m_axis_data_tdata  (tdata),
        .ovf                (ovf),
        .ovf_clr            (ovf_clr)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // n strobes, then 3 idle cycles; when a beat is expected it must appear
    // exactly 2 edges after the last strobe and tvalid must be low otherwise.
    task automatic burst(input string tag, input int n, input logic dec,
                         input logic [15:0] v0, input logic [15:0] v1, input logic ramp,
                         input logic [31:0] exp_beat, input logic expect_beat);
        decimate = dec;
        for (int c = 1; c <= n + 3; c++) begin
            adc_valid = (c <= n);
            d0 = ramp ? v0 + 16'(c - 1) : v0;
            d1 = v1;
            tick;
            if (expect_beat && c == n + 2) begin
                chk({tag, " tvalid"}, 32'(tvalid), 32'd1);
                chk({tag, " tdata"}, tdata, exp_beat);
            end else begin
                chk({tag, " idle"}, 32'(tvalid), 32'd0);
            end
        end
        adc_valid = 1'b0;
    endtask

    logic [31:0] exp_ramp;

    initial begin
`ifdef UTIL_FIR_DEC_ROUND_EN
        exp_ramp = 32'hFFFF0004;
`else
        exp_ramp = 32'hFFFF0003;
`endif
        // Reset, with a strobe held during reset that must be ignored.
        reset = 1'b1; adc_valid = 1'b1; decimate = 1'b0; tready = 1'b1;
        ovf_clr = 1'b0; d0 = 16'h1111; d1 = 16'h2222;
        tick; tick;
        chk("rst tvalid", 32'(tvalid), 32'd0);
        chk("rst tdata", tdata, 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        reset = 1'b0; adc_valid = 1'b0;
        tick; tick; tick;
        chk("rst ignore strobe", 32'(tvalid), 32'd0);

        // Pass-through, 5 back-to-back strobes, tready=1.
        decimate = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            adc_valid = (c <= 5); d0 = 16'h2000; d1 = 16'h4000;
            tick;
            if (c >= 3 && c <= 7) begin
                chk("pass tvalid", 32'(tvalid), 32'd1);
                chk("pass tdata", tdata, 32'h40002000);
            end else begin
                chk("pass idle", 32'(tvalid), 32'd0);
            end
        end
        adc_valid = 1'b0;
        chk("pass ovf", 32'(ovf), 32'd0);
        tick;

        // Decimate R=8: ramp, then extremes.
        burst("ramp", 8, 1'b1, 16'h0000, 16'hFFFF, 1'b1, exp_ramp, 1'b1);
        burst("extreme", 8, 1'b1, 16'h7FFF, 16'h8000, 1'b0, 32'h80007FFF, 1'b1);

        // Backpressure: 5 strobes into a 4-deep FIFO with tready=0.
        tready = 1'b0; decimate = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            adc_valid = (c <= 5); d0 = 16'(c); d1 = 16'h0000;
            tick;
            if (c >= 3) begin
                chk("bp stall tvalid", 32'(tvalid), 32'd1);
                chk("bp stall tdata", tdata, 32'd1);
            end
            if (c == 5) chk("bp ovf before drop", 32'(ovf), 32'd0);
            if (c >= 6) chk("bp ovf set", 32'(ovf), 32'd1);
        end
        adc_valid = 1'b0;
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        chk("bp ovf clr", 32'(ovf), 32'd0);
        tready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("bp drain tvalid", 32'(tvalid), 32'd1);
            chk("bp drain tdata", tdata, 32'(k));
            tick;
        end
        chk("bp drained", 32'(tvalid), 32'd0);
        chk("bp ovf stays clear", 32'(ovf), 32'd0);
        tick;

        // Mode toggle: partial frame discarded on each change.
        burst("tog dec3", 3, 1'b1, 16'h0011, 16'h0011, 1'b0, 32'd0, 1'b0);
        burst("tog pass", 1, 1'b0, 16'h0055, 16'h0000, 1'b0, 32'h00000055, 1'b1);
        burst("tog back", 8, 1'b1, 16'h0100, 16'h0100, 1'b0, 32'h01000100, 1'b1);

        // Reset mid-frame.
        burst("rst pre", 5, 1'b1, 16'h1234, 16'h1234, 1'b0, 32'd0, 1'b0);
        reset = 1'b1; adc_valid = 1'b1;
        tick;
        reset = 1'b0; adc_valid = 1'b0;
        chk("midrst tvalid", 32'(tvalid), 32'd0);
        chk("midrst tdata", tdata, 32'd0);
        burst("rst post", 8, 1'b1, 16'h0010, 16'h0010, 1'b0, 32'h00100010, 1'b1);
        chk("final ovf", 32'(ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
